dma_copy_16bit: RTL
===================

# dma_copy_16bit

Block-copy engine: the memory-side initiator for the 16-bit single-port RAM (sync write, combinational read). On a `start` pulse it moves `len` words from `src_addr` to `dst_addr` with one read and one write cycle per word, then pulses `done`. It sits beside the CPU core. External muxing, driven by `busy`, gives it the RAM port while it runs.

## Interface
- `DATA_WIDTH`, 16, word width; matches RAM data width.
- `ADDR_WIDTH`, 12, word address width; matches RAM depth of 2^ADDR_WIDTH.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `abort`  in  1  terminate transfer in progress.
- `src_addr`  in  ADDR_WIDTH  first source word address; sampled with `start`.
- `dst_addr`  in  ADDR_WIDTH  first destination word address; sampled with `start`.
- `len`  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the DONE state.
- `done`  out  1  one-cycle pulse on normal completion.
- `aborted`  out  1  one-cycle pulse when `abort` ends a transfer.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_din`  out  DATA_WIDTH  RAM write data.
- `ram_dout`  in  DATA_WIDTH  RAM read data; combinational from `ram_addr`.

## Operation
- States:
  - IDLE: `busy`=0, RAM outputs all 0.
  - READ: `ram_addr`=src_ptr, `ram_we`=0. Data register captures `ram_dout` at the edge.
  - WRITE: `ram_addr`=dst_ptr, `ram_we`=1, `ram_din`=data register.
  - DONE: `done`=1, RAM outputs 0.
- Transitions:
  - IDLE + `start`, `len`≠0 → READ. This loads src_ptr, dst_ptr and the remaining count.
  - IDLE + `start`, `len`=0 → DONE. No RAM access.
  - READ → WRITE.
  - WRITE → READ while remaining>1. Both pointers increment and remaining decrements.
  - WRITE → DONE when remaining=1.
  - DONE → IDLE.
- Pointers wrap modulo 2^ADDR_WIDTH; 0xFFF+1 → 0x000.
- Copy is strictly ascending, word by word. For overlapping regions with dst>src, already-written words are re-read. Example: dst=src+1 replicates word src across the region. This behaviour is defined and required.
- `start` while busy is ignored. It is not queued.
- `abort` in READ or WRITE → IDLE next edge and `aborted` pulses for 1 cycle.
  - A WRITE in the abort cycle still completes.
  - No further accesses occur and `done` does not pulse.
- `abort` in IDLE or DONE has no effect.
- Reset, async and at any time including mid-transfer: state IDLE, pointers, count and data register 0.
  - All outputs go 0 immediately: `busy`, `done`, `aborted`, `ram_we`, `ram_addr`, `ram_din`.
  - The interrupted transfer is lost.

## Timing
- Start accepted at edge E0. READ of word k occupies cycle 2k+1 after E0; WRITE occupies cycle 2k+2.
- `done` is high in cycle 2·len+1 after E0. `busy` drops the cycle after.
- `len`=0: `done` high in cycle 1 after E0.
- Throughput: 2 cycles per word (copy mode).
- RAM outputs are a combinational decode of registered state and pointers. They contain no `ram_dout`-to-output path.

## Configuration
- `DMA_FILL_EN` defined:
  - Adds `fill` (in, 1) and `pattern` (in, DATA_WIDTH), both sampled with `start`.
  - With `fill`=1 the data register loads `pattern` and the READ state is skipped: WRITE → WRITE, one word per cycle.
  - `done` is high in cycle len+1 after E0.
  - `abort`, wrap and reset rules are unchanged.
- `DMA_FILL_EN` undefined: these ports do not exist; copy mode only.

## Structure
- Package `dma_pkg`: state encoding localparams (IDLE, READ, WRITE, DONE), default widths.
- Sub-module `dma_ptr`: ADDR_WIDTH pointer with load/increment and natural wrap. It is instantiated twice, for src and dst.
- FSM, counter and data register live in `dma_copy_16bit`.

## Test plan
- Copy len=4, src=0x010 → dst=0x100, source 0xA000..0xA003 → dst holds same values; `done` high in cycle 9 after start; `ram_we` high exactly 4 cycles.
- len=0 → `done` in cycle 1, `ram_we` never asserted, memory unchanged.
- Wrap: src=0xFFE, len=3, dst=0x200 → reads 0xFFE, 0xFFF, 0x000 in order.
- Overlap: src=0x020 holds 0x1234, dst=0x021, len=3 → 0x021..0x023 all 0x1234.
- Abort in the second WRITE of len=8 → exactly 2 words written, `aborted` 1 cycle, no `done`; reset mid-transfer → all outputs 0 immediately and the next start works.
- With `DMA_FILL_EN`: fill=1, pattern=0xBEEF, len=5, dst=0x300 → 0x300..0x304 = 0xBEEF; `done` in cycle 6 after start.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copy_16bit block-copy engine.
// Holds the default data/address widths and the FSM state encoding.
package dma_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefAddrWidth = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_ptr.sv
// Address pointer for the copy engine: parallel load or increment by one,
// wrapping naturally modulo 2^AddrWidth. Load takes priority over increment.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (pointer clears to 0)
//   load_i         load load_val_i on the next edge
//   load_val_i     value to load
//   inc_i          increment on the next edge
//   ptr_o          current pointer value
module dma_ptr #(
  parameter int unsigned AddrWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] load_val_i,
  input  logic                 inc_i,
  output logic [AddrWidth-1:0] ptr_o
);

  logic [AddrWidth-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + AddrWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/dma_copy_16bit.sv
// Block-copy engine driving a single-port RAM (sync write, combinational read).
// On start it copies len words from src_addr to dst_addr, one READ and one
// WRITE cycle per word, strictly ascending, then pulses done for one cycle.
// abort during READ/WRITE returns to idle and pulses aborted instead.
//
// Optional feature (macro DMA_FILL_EN): adds fill/pattern inputs; a fill
// transfer writes pattern to len words starting at dst_addr, one per cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         request / terminate
//   src_addr, dst_addr   first source / destination word, sampled with start
//   len                  word count 0..2^ADDR_WIDTH, sampled with start
//   busy, done, aborted  status
//   ram_we, ram_addr,
//   ram_din, ram_dout    RAM port (outputs decoded from registered state only)
//   fill, pattern        (DMA_FILL_EN only) fill mode request and fill value
module dma_copy_16bit
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
`ifdef DMA_FILL_EN
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] pattern,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  dma_state_e            state_d, state_q;
  logic [ADDR_WIDTH:0]   rem_d, rem_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  fill_d, fill_q;
  logic                  aborted_d, aborted_q;

  logic                  ptr_load, ptr_inc;
  logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr;

  logic                  fill_req;
  logic [DATA_WIDTH-1:0] pattern_req;

`ifdef DMA_FILL_EN
  assign fill_req    = fill;
  assign pattern_req = pattern;
`else
  assign fill_req    = 1'b0;
  assign pattern_req = '0;
`endif

  dma_ptr #(
    .AddrWidth (ADDR_WIDTH)
  ) u_src_ptr (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (ptr_load),
    .load_val_i (src_addr),
    .inc_i      (ptr_inc),
    .ptr_o      (src_ptr)
  );

  dma_ptr #(
    .AddrWidth (ADDR_WIDTH)
  ) u_dst_ptr (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (ptr_load),
    .load_val_i (dst_addr),
    .inc_i      (ptr_inc),
    .ptr_o      (dst_ptr)
  );

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    data_d    = data_q;
    fill_d    = fill_q;
    aborted_d = 1'b0;
    ptr_load  = 1'b0;
    ptr_inc   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          ptr_load = 1'b1;
          rem_d    = len;
          fill_d   = fill_req;
          if (len == '0) begin
            state_d = StDone;
          end else if (fill_req) begin
            // Fill skips READ entirely; the data register holds the pattern.
            data_d  = pattern_req;
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        data_d = ram_dout;
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        // The write of this cycle lands at the edge regardless of abort.
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (rem_q > (ADDR_WIDTH + 1)'(1)) begin
          ptr_inc = 1'b1;
          rem_d   = rem_q - (ADDR_WIDTH + 1)'(1);
          state_d = fill_q ? StWrite : StRead;
        end else begin
          rem_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      data_q    <= '0;
      fill_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      fill_q    <= fill_d;
      aborted_q <= aborted_d;
    end
  end

  // Outputs: pure decode of registered state, no ram_dout feed-through.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    aborted  = aborted_q;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (state_q)
      StRead: begin
        ram_addr = src_ptr;
      end
      StWrite: begin
        ram_we   = 1'b1;
        ram_addr = dst_ptr;
        ram_din  = data_q;
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

endmodule
